// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM latch sequencer.
// Holds the sequencer state encoding, reset constants and the index-width helper.
package pwm_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SETUP,
      STROBE,
      RELEASE
   } seq_state_t;

   localparam int TON_RST = 0;
   localparam int OE_RST  = 0;

   // A single channel still needs a one-bit index.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_latch_sequencer_shadow.sv
// Shadow duty array with per-channel dirty flags for the PWM latch sequencer.
// A write in the same cycle as a dirty-clear wins, so that value stays pending.
module pwm_shadow_regs #(
   parameter int NB_PWM     = 24,
   parameter int RESOLUTION = 10,
   parameter int ADDR_W     = 5
) (
   input  logic                  ClkIn,
   input  logic                  nReset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [RESOLUTION-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_idx,
   output logic [RESOLUTION-1:0] rd_data,
   output logic                  rd_dirty,
   input  logic                  clr_en
);

   logic [RESOLUTION-1:0] shadow [NB_PWM];
   logic [NB_PWM-1:0]     dirty;

   always_ff @(posedge ClkIn or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < NB_PWM; i++) begin
            shadow[i] <= '0;
         end
         dirty <= '1;
      end else begin
         for (int i = 0; i < NB_PWM; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
               shadow[i] <= wr_data;
               dirty[i]  <= 1'b1;
            end else if (clr_en && (rd_idx == ADDR_W'(i))) begin
               dirty[i]  <= 1'b0;
            end
         end
      end
   end

   assign rd_data  = shadow[rd_idx];
   assign rd_dirty = dirty[rd_idx];

endmodule

// File: rtl/pwm_latch_sequencer.sv
// Loads changed duty values onto the shared Ton bus and strobes per-channel nLatch.
// Also owns the output-enable vector and the write address check.
//
//   state   | meaning
//   IDLE    | waiting for commit or a pending commit
//   SCAN    | test dirty[idx]; skip clean channels one per cycle
//   SETUP   | Ton loads shadow[idx] at the end of this cycle, dirty[idx] cleared
//   STROBE  | Ton valid; nLatch[idx] driven low at the end of this cycle
//   RELEASE | nLatch[idx] low; released at the end, then next channel or pass end
module pwm_latch_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int NB_PWM     = 24,
   parameter int RESOLUTION = 10,
   parameter int ADDR_W     = addr_w(NB_PWM)
) (
   input  logic                  ClkIn,
   input  logic                  nReset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [RESOLUTION-1:0] wr_data,
   output logic                  wr_err,
   input  logic                  commit,
   input  logic                  oe_wr,
   input  logic [NB_PWM-1:0]     oe_data,
   output logic                  busy,
   output logic [RESOLUTION-1:0] Ton,
   output logic [NB_PWM-1:0]     nLatch,
   output logic [NB_PWM-1:0]     oe
);

   seq_state_t            state, state_nxt;
   logic [ADDR_W-1:0]     idx, idx_nxt;
   logic                  commit_pending, pending_nxt;
   logic                  addr_ok;
   logic                  last;
   logic                  clr_en;
   logic [RESOLUTION-1:0] rd_data;
   logic                  rd_dirty;
   logic [NB_PWM-1:0]     nlatch_nxt;

   assign addr_ok = {1'b0, wr_addr} < (ADDR_W + 1)'(NB_PWM);
   assign last    = (idx == ADDR_W'(NB_PWM - 1));
   assign busy    = (state != IDLE);

   pwm_shadow_regs #(
      .NB_PWM     (NB_PWM),
      .RESOLUTION (RESOLUTION),
      .ADDR_W     (ADDR_W)
   ) u_shadow (
      .ClkIn    (ClkIn),
      .nReset   (nReset),
      .wr_en    (wr_en & addr_ok),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_idx   (idx),
      .rd_data  (rd_data),
      .rd_dirty (rd_dirty),
      .clr_en   (clr_en)
   );

   always_ff @(posedge ClkIn or negedge nReset) begin
      if (!nReset) begin
         state          <= IDLE;
         idx            <= '0;
         commit_pending <= 1'b0;
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         commit_pending <= pending_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      pending_nxt = commit_pending | commit;
      clr_en      = 1'b0;
      nlatch_nxt  = '1;
      case (state)
         IDLE: begin
            if (commit || commit_pending) begin
               state_nxt   = SCAN;
               idx_nxt     = '0;
               pending_nxt = 1'b0;
            end
         end
         SCAN: begin
            if (rd_dirty) begin
               state_nxt = SETUP;
            end else if (last) begin
               // A pending commit restarts the scan directly so busy never gaps.
               if (pending_nxt) begin
                  state_nxt   = SCAN;
                  idx_nxt     = '0;
                  pending_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               idx_nxt = idx + ADDR_W'(1);
            end
         end
         SETUP: begin
            clr_en    = 1'b1;
            state_nxt = STROBE;
         end
         STROBE: begin
            nlatch_nxt[idx] = 1'b0;
            state_nxt       = RELEASE;
         end
         RELEASE: begin
            if (last) begin
               if (pending_nxt) begin
                  state_nxt   = SCAN;
                  idx_nxt     = '0;
                  pending_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt = SCAN;
               idx_nxt   = idx + ADDR_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge ClkIn or negedge nReset) begin
      if (!nReset) begin
         Ton    <= RESOLUTION'(TON_RST);
         nLatch <= '1;
         oe     <= NB_PWM'(OE_RST);
         wr_err <= 1'b0;
      end else begin
         if (state == SETUP) begin
            Ton <= rd_data;
         end
         nLatch <= nlatch_nxt;
         if (oe_wr) begin
            oe <= oe_data;
         end
         wr_err <= wr_en & ~addr_ok;
      end
   end

endmodule

// File: tb/tb_pwm_latch_sequencer.sv
// Randomised self-checking bench for pwm_latch_sequencer.
// A channel-level model predicts strobe order, latched values and busy length per commit.
module tb_pwm_latch_sequencer;

   localparam int NB  = 24;
   localparam int RES = 10;
   localparam int AW  = 5;

   logic           ClkIn = 1'b0;
   logic           nReset = 1'b0;
   logic           wr_en = 1'b0;
   logic [AW-1:0]  wr_addr = '0;
   logic [RES-1:0] wr_data = '0;
   logic           commit = 1'b0;
   logic           oe_wr = 1'b0;
   logic [NB-1:0]  oe_data = '0;
   logic           wr_err;
   logic           busy;
   logic [RES-1:0] Ton;
   logic [NB-1:0]  nLatch;
   logic [NB-1:0]  oe;

   pwm_latch_sequencer #(.NB_PWM(NB), .RESOLUTION(RES)) dut (
      .ClkIn   (ClkIn),
      .nReset  (nReset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_err  (wr_err),
      .commit  (commit),
      .oe_wr   (oe_wr),
      .oe_data (oe_data),
      .busy    (busy),
      .Ton     (Ton),
      .nLatch  (nLatch),
      .oe      (oe)
   );

   always #5 ClkIn = ~ClkIn;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ClkIn);
      #1;
   endtask

   // PWM bank view: every nLatch falling edge captures Ton.
   logic [NB-1:0]  prev_nl = '1;
   logic [RES-1:0] prev_ton = '0;
   logic [RES-1:0] post_ton = '0;
   bit             post_chk = 1'b0;
   int             mon_ch;
   int             q_ch[$];
   logic [RES-1:0] q_ton[$];

   always @(negedge ClkIn) begin
      if (post_chk) begin
         check("ton_hold_after", Ton, post_ton);
         check("latch_one_cycle", nLatch, {NB{1'b1}});
         post_chk = 1'b0;
      end
      if ((prev_nl & ~nLatch) != '0) begin
         mon_ch = -1;
         for (int i = 0; i < NB; i++) begin
            if (prev_nl[i] && !nLatch[i]) mon_ch = i;
         end
         check("one_low", $countones(~nLatch), 1);
         check("ton_setup_before", Ton, prev_ton);
         q_ch.push_back(mon_ch);
         q_ton.push_back(Ton);
         post_chk = 1'b1;
         post_ton = Ton;
      end
      prev_nl  = nLatch;
      prev_ton = Ton;
   end

   logic [RES-1:0] m_shadow [NB];
   bit             m_dirty  [NB];

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_shadow[i] = '0;
         m_dirty[i]  = 1'b1;
      end
   endtask

   task automatic do_write(input int ch, input logic [RES-1:0] val);
      wr_en   = 1'b1;
      wr_addr = AW'(ch);
      wr_data = val;
      tick();
      wr_en = 1'b0;
      check("wr_err", wr_err, (ch >= NB));
      if (ch < NB) begin
         m_shadow[ch] = val;
         m_dirty[ch]  = 1'b1;
      end else begin
         tick();
         check("wr_err_pulse", wr_err, 0);
      end
   endtask

   // One commit; optionally a write at busy cycle w_cyc, three extra commits, or an oe load.
   task automatic run_pass(input int extra, input int w_cyc, input int w_ch,
                           input logic [RES-1:0] w_val, input int oe_cyc,
                           input logic [NB-1:0] oe_val);
      int             exp_ch[$];
      logic [RES-1:0] exp_ton[$];
      int             exp_cyc;
      int             cyc;
      int             n;
      q_ch.delete();
      q_ton.delete();
      n = 0;
      for (int i = 0; i < NB; i++) begin
         if (m_dirty[i]) begin
            exp_ch.push_back(i);
            exp_ton.push_back(m_shadow[i]);
            m_dirty[i] = 1'b0;
            n++;
         end
      end
      exp_cyc = NB + 3 * n;
      if (w_cyc >= 0) begin
         m_shadow[w_ch] = w_val;
         m_dirty[w_ch]  = 1'b1;
      end
      if (extra > 0) begin
         n = 0;
         for (int i = 0; i < NB; i++) begin
            if (m_dirty[i]) begin
               exp_ch.push_back(i);
               exp_ton.push_back(m_shadow[i]);
               m_dirty[i] = 1'b0;
               n++;
            end
         end
         exp_cyc += NB + 3 * n;
      end
      commit = 1'b1;
      tick();
      commit = 1'b0;
      cyc = 0;
      while (busy && cyc < 2000) begin
         if (cyc == w_cyc) begin
            wr_en   = 1'b1;
            wr_addr = AW'(w_ch);
            wr_data = w_val;
         end
         if (extra > 0 && (cyc == 2 || cyc == 5 || cyc == 9)) commit = 1'b1;
         if (cyc == oe_cyc) begin
            oe_wr   = 1'b1;
            oe_data = oe_val;
         end
         tick();
         cyc++;
         if (oe_wr) check("oe_while_busy", oe, oe_val);
         wr_en  = 1'b0;
         commit = 1'b0;
         oe_wr  = 1'b0;
      end
      check("busy_cycles", cyc, exp_cyc);
      check("n_strobes", q_ch.size(), exp_ch.size());
      for (int i = 0; i < q_ch.size() && i < exp_ch.size(); i++) begin
         check("strobe_ch", q_ch[i], exp_ch[i]);
         check("strobe_ton", q_ton[i], exp_ton[i]);
      end
   endtask

   task automatic reset_mid_strobe();
      logic [RES-1:0] v10;
      int             k;
      bit             found;
      for (int i = 0; i < NB; i++) do_write(i, RES'(i * 41 + 7));
      v10 = RES'(10 * 41 + 7);
      q_ch.delete();
      q_ton.delete();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      found = 1'b0;
      k = 0;
      // First cycle showing ch10's value is its STROBE cycle.
      while (!found && k < 300) begin
         if (Ton == v10 && nLatch == {NB{1'b1}}) found = 1'b1;
         else begin
            tick();
            k++;
         end
      end
      check("reach_strobe_ch10", found, 1);
      nReset = 1'b0;
      #1;
      check("rst_nlatch", nLatch, {NB{1'b1}});
      check("rst_ton", Ton, 0);
      check("rst_busy", busy, 0);
      check("strobes_before_rst", q_ch.size(), 10);
      tick();
      tick();
      nReset = 1'b1;
      model_reset();
      tick();
      check("no_fall_ch10", q_ch.size(), 10);
   endtask

   initial begin
      int             nw;
      logic [NB-1:0]  rnd_oe;
      model_reset();
      nReset = 1'b0;
      tick();
      tick();
      nReset = 1'b1;
      tick();
      check("rst_ton0", Ton, 0);
      check("rst_nlatch0", nLatch, {NB{1'b1}});
      check("rst_oe0", oe, 0);
      check("rst_busy0", busy, 0);
      check("rst_wr_err0", wr_err, 0);

      run_pass(0, -1, 0, '0, -1, '0);

      do_write(5, 10'h3FF);
      do_write(17, 10'h155);
      run_pass(0, -1, 0, '0, -1, '0);

      do_write(3, 10'h111);
      run_pass(0, 4, 3, 10'h0AA, -1, '0);
      run_pass(0, -1, 0, '0, -1, '0);

      do_write(1, 10'h2C3);
      run_pass(3, -1, 0, '0, -1, '0);

      do_write(24 + $urandom_range(0, 7), 10'h3C3);
      oe_wr   = 1'b1;
      oe_data = 24'hA5A5A5;
      tick();
      oe_wr = 1'b0;
      check("oe_idle", oe, 24'hA5A5A5);
      run_pass(0, -1, 0, '0, 3, 24'h5A5A5A);

      for (int it = 0; it < 8; it++) begin
         nw = $urandom_range(0, 5);
         for (int j = 0; j < nw; j++) do_write($urandom_range(0, 27), RES'($urandom));
         rnd_oe = NB'($urandom);
         run_pass(0, -1, 0, '0, $urandom_range(0, 20), rnd_oe);
      end

      reset_mid_strobe();
      run_pass(0, -1, 0, '0, -1, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
